bus_arb: RTL

Central arbiter for the shared split address/data bus used by the video and memory-client blocks.
- Each requester presents a 2-bit bid level and a 2-bit burst-length code.
- The arbiter grants the bus to one requester at a time and holds the grant for the full burst.
- It inserts a one-cycle turnaround between owners and reclaims the bus from a stalled owner via a beat timeout.

---
 rtl/bus_pkg.sv | 42 ++++
 rtl/bus_arb_pick.sv | 46 ++++
 rtl/bus_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_pkg
// Brief  : Shared types, burst-length decode and command codes for the bus.
// Rev    : 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        LO   = 2'b01,
        MID  = 2'b10,
        HI   = 2'b11
    } bid_t;

    typedef enum logic [1:0] {
        LEN1 = 2'b00,
        LEN2 = 2'b01,
        LEN4 = 2'b10,
        LEN8 = 2'b11
    } len_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        GAP  = 2'b10
    } arb_state_t;

    localparam logic [2:0] CMD_WR_REQ = 3'b100;
    localparam logic [2:0] CMD_WR_RSP = 3'b101;

    function automatic logic [3:0] len_beats(input len_t code);
        case (code)
            LEN1:    len_beats = 4'd1;
            LEN2:    len_beats = 4'd2;
            LEN4:    len_beats = 4'd4;
            default: len_beats = 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : arb_pick
// Brief  : Combinational winner select: highest bid, ties round-robin after rr_ptr.
// Rev    : 1.0
// ============================================================================
module arb_pick
    import bus_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [2*NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0]   rr_ptr,
    output logic                      valid,
    output logic [$clog2(NREQ)-1:0]   winner
);

    localparam int c_idw = $clog2(NREQ);

    bid_t w_max_lvl;
    logic w_found;
    int   w_idx;

    always_comb begin
        w_max_lvl = NONE;
        w_found   = 1'b0;
        w_idx     = 0;
        winner    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bid_t'(req[2*i +: 2]) > w_max_lvl) begin
                w_max_lvl = bid_t'(req[2*i +: 2]);
            end
        end
        valid = (w_max_lvl != NONE);
        // Scan starts one past the last owner so it is the lowest priority tie.
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = (int'(rr_ptr) + off) % NREQ;
            if (valid && !w_found && (bid_t'(req[2*w_idx +: 2]) == w_max_lvl)) begin
                winner  = c_idw'(w_idx);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arb.sv
`default_nettype none
// ============================================================================
// Module : bus_arb
// Brief  : Burst-holding bus arbiter with one-cycle turnaround and beat timeout.
// Rev    : 1.0
// ============================================================================
module bus_arb
    import bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]         len,
    input  logic                      beat,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int c_idw = $clog2(NREQ);
    localparam int c_tow = $clog2(TIMEOUT);
    localparam logic [NREQ-1:0]  c_gnt_lsb = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [c_tow-1:0] c_to_last = c_tow'(TIMEOUT - 2);
    localparam logic [c_tow-1:0] c_to_one  = c_tow'(1);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [c_idw-1:0] gnt_id_q, gnt_id_d;
    logic [c_idw-1:0] rr_ptr_q, rr_ptr_d;
    len_t             len_q, len_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [c_tow-1:0] to_cnt_q, to_cnt_d;
    logic             terr_q, terr_d;

    logic             w_pick_valid;
    logic [c_idw-1:0] w_pick_id;
    logic [1:0]       w_owner_req;
    logic             w_leave;

    arb_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (w_pick_valid),
        .winner (w_pick_id)
    );

    assign w_owner_req = req[2*gnt_id_q +: 2];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        terr_d     = 1'b0;
        w_leave    = 1'b0;
        case (state_q)
            XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    to_cnt_d   = '0;
                end else begin
                    to_cnt_d   = to_cnt_q + c_to_one;
                end
                // Completion wins over abort, abort wins over timeout.
                if (beat && ((beat_cnt_q + 4'd1) == len_beats(len_q))) begin
                    w_leave = 1'b1;
                end else if (w_owner_req == 2'b00) begin
                    w_leave = 1'b1;
                end else if (!beat && (to_cnt_q == c_to_last)) begin
                    w_leave = 1'b1;
                    terr_d  = 1'b1;
                end
                if (w_leave) begin
                    state_d    = GAP;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; only the entry path differs.
                state_d    = IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
                to_cnt_d   = '0;
                if (w_pick_valid) begin
                    state_d  = XFER;
                    gnt_d    = c_gnt_lsb << w_pick_id;
                    gnt_id_d = w_pick_id;
                    rr_ptr_d = w_pick_id;
                    len_d    = len_t'(len[2*w_pick_id +: 2]);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= c_idw'(NREQ - 1);
            len_q      <= LEN1;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            terr_q     <= terr_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = (state_q == XFER);
    assign timeout_err = terr_q;

endmodule
`default_nettype wire
